// File: rtl/qt_pkg.sv
// Shared teleportation-protocol definitions: FSM states, classical
// message codes and the measurement LFSR shape. Bob's correction block
// decodes the same MSG_* codes.
package qt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTANGLE = 3'd1,
    ST_CNOT     = 3'd2,
    ST_HADAMARD = 3'd3,
    ST_MEASURE  = 3'd4,
    ST_SEND     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  // Message bit0 = m_x (apply X), bit1 = m_z (apply Z)
  localparam logic [1:0] MSG_I  = 2'b00;
  localparam logic [1:0] MSG_X  = 2'b01;
  localparam logic [1:0] MSG_Z  = 2'b10;
  localparam logic [1:0] MSG_XZ = 2'b11;

  localparam int unsigned LFSR_W = 16;
  // Feedback taps at bits 15, 13, 12 and 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // One left shift of the Fibonacci LFSR
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/qt_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR supplying measurement outcomes.
// An all-zero seed would lock the register up, so it is replaced by 1.
module qt_lfsr16
  import qt_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] q
);

  localparam logic [LFSR_W-1:0] SEED_SAFE =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  // Shift every cycle; synchronous active-high reset reloads the seed
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_lfsr <= SEED_SAFE;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/alice_measure_tx.sv
// Alice-side teleport sender: sequences the gate phases, measures,
// and hands the 2-bit classical message to Bob with a valid/ready
// handshake. bob_raw is Bob's qubit before correction, for end-to-end
// checking. GATE_CYCLES must lie in 1..15 (4-bit phase counter).
//
//   state    | meaning
//   IDLE     | waiting for start
//   ENTANGLE | Bell-pair preparation, GATE_CYCLES long
//   CNOT     | CNOT psi->Alice half, GATE_CYCLES long
//   HADAMARD | H on psi, GATE_CYCLES long
//   MEASURE  | sample {m_z,m_x}, register message and bob_raw
//   SEND     | raise msg_valid, hold until msg_ready
//   DONE     | one-cycle done pulse
module alice_measure_tx
  import qt_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned GATE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] psi_in,
  input  logic       meas_force_en,
  input  logic [1:0] meas_force,
  output logic       busy,
  output logic       msg_valid,
  output logic [1:0] msg_data,
  input  logic       msg_ready,
  output logic [1:0] bob_raw,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam logic [3:0] GATE_LAST = 4'(GATE_CYCLES - 1);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [1:0]        r_psi;
  logic              r_busy;
  logic              r_msg_valid;
  logic [1:0]        r_msg_data;
  logic [1:0]        r_bob_raw;
  logic              r_done;

  logic [LFSR_W-1:0] w_lfsr;
  logic [1:0]        w_meas;
  logic              w_gate_last;

  qt_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (w_lfsr)
  );

  assign w_meas      = meas_force_en ? meas_force : w_lfsr[1:0];
  assign w_gate_last = (r_cnt == GATE_LAST);

  // Teleport sequencer with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_psi       <= 2'b00;
      r_busy      <= 1'b0;
      r_msg_valid <= 1'b0;
      r_msg_data  <= 2'b00;
      r_bob_raw   <= 2'b00;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_psi   <= psi_in;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= ST_ENTANGLE;
          end
        end
        ST_ENTANGLE, ST_CNOT, ST_HADAMARD: begin
          if (w_gate_last) begin
            r_cnt   <= 4'd0;
            r_state <= (r_state == ST_ENTANGLE) ? ST_CNOT :
                       (r_state == ST_CNOT)     ? ST_HADAMARD : ST_MEASURE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        ST_MEASURE: begin
          r_msg_data <= w_meas;
          r_bob_raw  <= r_psi ^ w_meas;
          r_state    <= ST_SEND;
        end
        ST_SEND: begin
          // msg_valid rises on the first SEND cycle; ready only counts once it is up
          if (!r_msg_valid) begin
            r_msg_valid <= 1'b1;
          end else if (msg_ready) begin
            r_msg_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_msg_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign msg_valid = r_msg_valid;
  assign msg_data  = r_msg_data;
  assign bob_raw   = r_bob_raw;
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_alice_measure_tx.sv
// Bench for alice_measure_tx: directed protocol cases plus randomized
// teleports checked against a cycle-indexed LFSR history and a Bob-side
// correction model.
module tb_alice_measure_tx;
  import qt_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start, meas_force_en, msg_ready;
  logic [1:0] psi_in, meas_force;
  logic       busy, msg_valid, done;
  logic [1:0] msg_data, bob_raw;
  logic [2:0] state_dbg;

  logic       start_3, meas_force_en_3, msg_ready_3;
  logic [1:0] psi_in_3, meas_force_3;
  logic       busy_3, msg_valid_3, done_3;
  logic [1:0] msg_data_3, bob_raw_3;
  logic [2:0] state_dbg_3;

  alice_measure_tx #(.LFSR_SEED(SEED), .GATE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .psi_in(psi_in),
    .meas_force_en(meas_force_en), .meas_force(meas_force),
    .busy(busy), .msg_valid(msg_valid), .msg_data(msg_data),
    .msg_ready(msg_ready), .bob_raw(bob_raw), .done(done),
    .state_dbg(state_dbg)
  );

  alice_measure_tx #(.LFSR_SEED(SEED), .GATE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start_3), .psi_in(psi_in_3),
    .meas_force_en(meas_force_en_3), .meas_force(meas_force_3),
    .busy(busy_3), .msg_valid(msg_valid_3), .msg_data(msg_data_3),
    .msg_ready(msg_ready_3), .bob_raw(bob_raw_3), .done(done_3),
    .state_dbg(state_dbg_3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference LFSR: taps 15,13,12,10, shift left, reset to seed
  function automatic logic [15:0] ref_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Bob applies X for m_x and Z for m_z; in basis emulation X flips bit0, Z flips bit1
  function automatic logic [1:0] bob_correct(input logic [1:0] raw, input logic [1:0] msg);
    logic [1:0] c;
    case (msg)
      MSG_I:   c = raw;
      MSG_X:   c = {raw[1], ~raw[0]};
      MSG_Z:   c = {~raw[1], raw[0]};
      default: c = ~raw;
    endcase
    return c;
  endfunction

  logic [15:0] mdl_lfsr;
  logic [15:0] hist [0:16383];
  int          cyc = 0;
  int          done_cnt = 0;
  logic [3:0]  seen_codes = 4'b0000;

  // hist[n] holds the LFSR value sampled at clock edge n
  always @(posedge clk) begin
    hist[cyc % 16384] <= mdl_lfsr;
    cyc               <= cyc + 1;
    mdl_lfsr          <= rst_n ? SEED : ref_step(mdl_lfsr);
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic teleport(input logic [1:0] psi, input logic fen, input logic [1:0] fval,
                          input int ready_wait, input string tag);
    int         e0, n;
    logic [1:0] exp_msg;
    msg_ready     = (ready_wait == 0);
    psi_in        = psi;
    meas_force_en = fen;
    meas_force    = fval;
    start         = 1'b1;
    tick;
    start = 1'b0;
    e0    = cyc - 1;
    check_eq({tag, " busy"}, busy, 1);
    n = 0;
    while (!msg_valid && n < 40) begin
      tick;
      n++;
    end
    check_eq({tag, " latency"}, n, 5);
    if (!msg_valid) begin
      msg_ready = 1'b0;
      return;
    end
    exp_msg = fen ? fval : hist[(e0 + 4) % 16384][1:0];
    seen_codes[msg_data] = 1'b1;
    check_eq({tag, " msg_data"}, msg_data, exp_msg);
    check_eq({tag, " bob_raw"}, bob_raw, psi ^ exp_msg);
    check_eq({tag, " corrected"}, bob_correct(bob_raw, msg_data), psi);
    for (int i = 0; i < ready_wait; i++) begin
      tick;
      check_eq({tag, " hold valid"}, msg_valid, 1);
      check_eq({tag, " hold data"}, msg_data, exp_msg);
      check_eq({tag, " hold raw"}, bob_raw, psi ^ exp_msg);
      check_eq({tag, " hold no done"}, done, 0);
    end
    msg_ready = 1'b1;
    tick;
    check_eq({tag, " done pulse"}, done, 1);
    check_eq({tag, " valid drop"}, msg_valid, 0);
    check_eq({tag, " state DONE"}, state_dbg, 6);
    msg_ready = 1'b0;
    tick;
    check_eq({tag, " done end"}, done, 0);
    check_eq({tag, " idle"}, state_dbg, 0);
    check_eq({tag, " not busy"}, busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n, d0;
    rst_n = 1'b1;
    start = 0; meas_force_en = 0; msg_ready = 0; psi_in = 0; meas_force = 0;
    start_3 = 0; meas_force_en_3 = 0; msg_ready_3 = 0; psi_in_3 = 0; meas_force_3 = 0;
    repeat (3) tick;

    check_eq("rst state", state_dbg, 0);
    check_eq("rst busy", busy, 0);
    check_eq("rst msg_valid", msg_valid, 0);
    check_eq("rst msg_data", msg_data, 0);
    check_eq("rst bob_raw", bob_raw, 0);
    check_eq("rst done", done, 0);
    check_eq("rst lfsr", dut.w_lfsr, SEED);
    rst_n = 1'b0;
    tick;

    // Reset during CNOT
    meas_force_en = 1; meas_force = 2'b11; psi_in = 2'b11;
    start = 1; tick; start = 0;
    tick;
    check_eq("midrst in CNOT", state_dbg, 2);
    rst_n = 1'b1;
    tick;
    check_eq("midrst state", state_dbg, 0);
    check_eq("midrst busy", busy, 0);
    check_eq("midrst valid", msg_valid, 0);
    check_eq("midrst lfsr", dut.w_lfsr, SEED);
    rst_n = 1'b0;
    tick;

    teleport(2'b01, 1'b1, 2'b00, 0, "f00");
    teleport(2'b10, 1'b1, 2'b11, 4, "f11");

    // start pulses during HADAMARD, SEND and DONE are ignored
    d0 = done_cnt;
    msg_ready = 0; meas_force_en = 1; meas_force = 2'b01; psi_in = 2'b00;
    start = 1; tick; start = 0;
    tick; tick;
    check_eq("busy-start in HAD", state_dbg, 3);
    start = 1; tick; start = 0;
    check_eq("busy-start MEASURE", state_dbg, 4);
    tick; tick;
    check_eq("busy-start valid", msg_valid, 1);
    start = 1; tick; start = 0;
    check_eq("busy-start SEND held", msg_valid, 1);
    check_eq("busy-start data", msg_data, 2'b01);
    msg_ready = 1; tick; msg_ready = 0;
    check_eq("busy-start done", done, 1);
    start = 1; tick; start = 0;
    check_eq("busy-start idle", busy, 0);
    for (int i = 0; i < 10; i++) begin
      tick;
      check_eq("busy-start no rerun", busy, 0);
    end
    check_eq("busy-start done count", done_cnt - d0, 1);

    // GATE_CYCLES=3 instance
    psi_in_3 = 2'b01; meas_force_en_3 = 1; meas_force_3 = 2'b10; msg_ready_3 = 1;
    start_3 = 1; tick; start_3 = 0;
    n = 0;
    while (!msg_valid_3 && n < 60) begin
      tick;
      n++;
    end
    check_eq("g3 latency", n, 11);
    check_eq("g3 msg_data", msg_data_3, 2'b10);
    check_eq("g3 bob_raw", bob_raw_3, 2'b11);
    tick;
    check_eq("g3 done", done_3, 1);
    msg_ready_3 = 0;

    // Random closure with LFSR outcomes
    for (int r = 0; r < 200; r++) begin
      repeat ($urandom_range(0, 3)) tick;
      teleport(2'($urandom_range(0, 3)), 1'b0, 2'b00, int'($urandom_range(0, 2)), "rnd");
    end
    check_eq("all codes seen", seen_codes, 4'hF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
